// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlap control and a saturating match counter.
// Define SEQDET_MASK_EN to add a per-bit don't-care mask (pat_mask) loaded alongside the pattern.
module seq_pattern_detector #(
    parameter int unsigned           PAT_W   = 4,
    parameter logic [PAT_W-1:0]      PAT_RST = 4'b1011,
    parameter int unsigned           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             overlap,
    input  logic             x_vld,
    input  logic             x,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        ST_FILL,
        ST_ARMED
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               z_q, z_d;
    logic [PAT_W-1:0]   hist_new;
    logic [FILL_W-1:0]  fill_new;
    logic [PAT_W-1:0]   care;
    logic               hit;

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0]   mask_q, mask_d;
    assign care = ~mask_q;
`else
    assign care = {PAT_W{1'b1}};
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            pat_q   <= PAT_RST;
            fill_q  <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
`ifdef SEQDET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // Candidate history after shifting in the current bit
    assign hist_new = {hist_q[PAT_W-2:0], x};
    assign fill_new = (fill_q == FILL_FULL) ? FILL_FULL : FILL_W'(fill_q + FILL_W'(1));
    assign hit      = (fill_new == FILL_FULL) && (((hist_new ^ pat_q) & care) == '0);

    // Next-state and datapath update; priority clr > pat_ld > x_vld
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        z_d     = 1'b0;
`ifdef SEQDET_MASK_EN
        mask_d  = mask_q;
`endif
        if (clr) begin
            state_d = ST_FILL;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
        end else if (pat_ld) begin
            state_d = ST_FILL;
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
`ifdef SEQDET_MASK_EN
            mask_d  = pat_mask;
`endif
        end else if (x_vld) begin
            hist_d = hist_new;
            fill_d = fill_new;
            case (state_q)
                ST_FILL:  if (fill_new == FILL_FULL) state_d = ST_ARMED;
                ST_ARMED: state_d = ST_ARMED;
                default:  state_d = ST_FILL;
            endcase
            if (hit) begin
                z_d = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                // Non-overlapping mode discards the matched bits
                if (!overlap) begin
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            end
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign armed     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector (PAT_W=4, CNT_W=2): directed cases plus random traffic
// compared against a queue-based reference model.
module tb_seq_pattern_detector;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr, pat_ld, overlap, x_vld, x;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] pat_mask;
    logic             z, armed;
    logic [CNT_W-1:0] match_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int z_seen  = 0;

    // Reference model: the valid bits since the last flush, oldest first
    bit               mq[$];
    logic [PAT_W-1:0] mpat;
    logic [PAT_W-1:0] mmask;
    int               mcnt;
    bit               mz;

    always #5 clk = ~clk;

    seq_pattern_detector #(
        .PAT_W   (PAT_W),
        .PAT_RST (4'b1011),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .pat_ld    (pat_ld),
        .pat_in    (pat_in),
`ifdef SEQDET_MASK_EN
        .pat_mask  (pat_mask),
`endif
        .overlap   (overlap),
        .x_vld     (x_vld),
        .x         (x),
        .z         (z),
        .match_cnt (match_cnt),
        .armed     (armed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit();
        if (mq.size() != PAT_W) return 1'b0;
        for (int i = 0; i < PAT_W; i++) begin
            if (!mmask[PAT_W-1-i] && (mq[i] != mpat[PAT_W-1-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpat  = 4'b1011;
        mmask = '0;
        mcnt  = 0;
        mz    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".z"},     32'(z),         32'(mz));
        check({tag, ".cnt"},   32'(match_cnt), 32'(mcnt));
        check({tag, ".armed"}, 32'(armed),     32'(mq.size() == PAT_W));
    endtask

    // One clock: drive inputs, advance the model, compare one step after the edge
    task automatic step(input bit c, input bit ld, input logic [PAT_W-1:0] pin,
                        input logic [PAT_W-1:0] pm, input bit ov, input bit v, input bit b,
                        input string tag);
        clr = c; pat_ld = ld; pat_in = pin; pat_mask = pm; overlap = ov; x_vld = v; x = b;
        @(posedge clk);
        mz = 1'b0;
        if (c) begin
            mq.delete();
            mcnt = 0;
        end else if (ld) begin
            mpat = pin;
`ifdef SEQDET_MASK_EN
            mmask = pm;
`endif
            mq.delete();
        end else if (v) begin
            mq.push_back(b);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            if (model_hit()) begin
                mz   = 1'b1;
                mcnt = (mcnt < CNT_MAX) ? mcnt + 1 : CNT_MAX;
                if (!ov) mq.delete();
            end
        end
        #1;
        if (z === 1'b1) z_seen++;
        check_all(tag);
    endtask

    task automatic send(input logic [PAT_W-1:0] bits, input int n, input bit ov, input int gap,
                        input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(0, 0, '0, '0, ov, 1, bits[i], tag);
            for (int g = 0; g < gap; g++) step(0, 0, '0, '0, ov, 0, 1'b0, {tag, ".gap"});
        end
    endtask

    task automatic do_clr();
        step(1, 0, '0, '0, 0, 0, 1'b0, "clr");
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 0; pat_ld = 0; pat_in = '0; pat_mask = '0; overlap = 0; x_vld = 0; x = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.z",     32'(z),         32'd0);
        check("reset.cnt",   32'(match_cnt), 32'd0);
        check("reset.armed", 32'(armed),     32'd0);
        #2 rst_n = 1'b1;

        // overlap=1: 1,0,1,1,0,1,1 -> two matches
        send(4'b1011, 4, 1, 0, "ov1.a");
        check("ov1.z4", 32'(z), 32'd1);
        send(4'b0011, 3, 1, 0, "ov1.b");
        check("ov1.z7", 32'(z), 32'd1);
        check("ov1.cnt", 32'(match_cnt), 32'd2);
        do_clr();

        // overlap=0: same bits -> one match, disarmed afterwards
        send(4'b1011, 4, 0, 0, "ov0.a");
        check("ov0.z4", 32'(z), 32'd1);
        check("ov0.armed", 32'(armed), 32'd0);
        send(4'b0011, 3, 0, 0, "ov0.b");
        check("ov0.cnt", 32'(match_cnt), 32'd1);
        do_clr();

        // Gaps between valid bits are transparent
        z_seen = 0;
        send(4'b1011, 4, 0, 3, "gap");
        check("gap.zcount", 32'(z_seen), 32'd1);
        do_clr();

        // Saturation: five non-overlapping matches, counter stops at 3
        z_seen = 0;
        for (int r = 0; r < 5; r++) send(4'b1011, 4, 0, 0, "sat");
        check("sat.zcount", 32'(z_seen), 32'd5);
        check("sat.cnt", 32'(match_cnt), 32'd3);
        do_clr();

        // Reset mid-stream loses partial history
        send(4'b0101, 3, 1, 0, "rst.pre");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.async.z",   32'(z),         32'd0);
        check("rst.async.cnt", 32'(match_cnt), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        send(4'b0001, 1, 1, 0, "rst.post");
        check("rst.noz", 32'(z), 32'd0);
        check("rst.cnt", 32'(match_cnt), 32'd0);

        // pat_ld wins over x_vld in the same cycle
        step(0, 1, 4'b0110, '0, 1, 1, 1'b1, "ld");
        check("ld.armed", 32'(armed), 32'd0);
        send(4'b0110, 4, 1, 0, "ld.seq");
        check("ld.z", 32'(z), 32'd1);

`ifdef SEQDET_MASK_EN
        step(0, 1, 4'b1011, 4'b0100, 1, 0, 1'b0, "mask.ld");
        send(4'b1111, 4, 1, 0, "mask");
        check("mask.z", 32'(z), 32'd1);
        pat_mask = '0;
`endif

        // Random traffic; short patterns and dense valid bits give frequent matches
        for (int i = 0; i < 2000; i++) begin
            automatic int r = $urandom_range(0, 99);
            automatic logic [PAT_W-1:0] rp = PAT_W'($urandom_range(0, 15));
            automatic logic [PAT_W-1:0] rm = ($urandom_range(0, 3) == 0) ? PAT_W'($urandom_range(0, 15)) : '0;
            step(r < 2, (r >= 2) && (r < 5), rp, rm, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
